// File: rtl/pwm_pkg.sv
// Shared types and constants for the swerve rotation motor PWM stage.
package pwm_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_BRAKE = 2'd2
    } pwm_state_e;

    localparam logic [7:0] PWM_MAX = 8'd255;
    localparam logic [7:0] CNT_TOP = 8'd254;

    // Move cur toward tgt by at most step. The distance is compared in 9 bits;
    // the 8-bit add/sub cannot wrap because it only happens when step < distance.
    function automatic logic [7:0] slew_toward(input logic [7:0] cur,
                                               input logic [7:0] tgt,
                                               input logic [7:0] step);
        logic [8:0] w_diff;
        logic [7:0] w_res;
        if (tgt >= cur) begin
            w_diff = {1'b0, tgt} - {1'b0, cur};
            w_res  = (w_diff > {1'b0, step}) ? (cur + step) : tgt;
        end else begin
            w_diff = {1'b0, cur} - {1'b0, tgt};
            w_res  = (w_diff > {1'b0, step}) ? (cur - step) : tgt;
        end
        return w_res;
    endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Prescaler plus 0..254 PWM count; flags the last cycle of each PWM period.
module pwm_period_counter #(
    parameter int CLK_DIV = 4
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_enable,
    output logic [7:0] o_cnt,
    output logic       o_boundary
);
    import pwm_pkg::*;

    localparam int            PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_TOP = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_pre;
    logic [7:0]    r_cnt;
    logic          w_tick;

    assign w_tick     = i_enable && (r_pre == PRE_TOP);
    assign o_boundary = w_tick && (r_cnt == CNT_TOP);
    assign o_cnt      = r_cnt;

    // Disabling the output parks the count at zero so a re-enable starts a clean period.
    always_ff @(posedge i_clock) begin
        if (i_reset || !i_enable) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
            r_cnt <= (r_cnt == CNT_TOP) ? 8'd0 : (r_cnt + 8'd1);
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

endmodule

// File: rtl/pwm_generator.sv
// Motor PWM/DIR driver: ratio changes land on period boundaries, are slew-limited,
// and a direction reversal ramps to zero and brakes before DIR flips.
module pwm_generator #(
    parameter int CLK_DIV       = 4,
    parameter int RAMP_STEP     = 8,
    parameter int BRAKE_PERIODS = 2
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_pwm_enable,
    input  logic [7:0] i_pwm_ratio,
    input  logic       i_pwm_direction,
    input  logic       i_pwm_update,
    output logic       o_pwm_done,
    output logic       o_pwm_out,
    output logic       o_dir_out,
    output logic [7:0] o_applied_ratio
);
    import pwm_pkg::*;

    localparam logic [7:0]    STEP       = (RAMP_STEP >= 255) ? PWM_MAX : 8'(RAMP_STEP);
    localparam int            BW         = $clog2(BRAKE_PERIODS + 1);
    localparam logic [BW-1:0] BRAKE_LAST = BW'(BRAKE_PERIODS - 1);

    pwm_state_e    r_state;
    pwm_state_e    w_state_nxt;
    logic [7:0]    r_applied;
    logic [7:0]    w_applied_nxt;
    logic [7:0]    r_target;
    logic [7:0]    w_goal;
    logic [7:0]    w_slewed;
    logic [7:0]    w_cnt;
    logic [BW-1:0] r_brake_cnt;
    logic [BW-1:0] w_brake_nxt;
    logic          r_dir;
    logic          w_dir_nxt;
    logic          r_tdir;
    logic          r_pending;
    logic          r_done;
    logic          w_done_nxt;
    logic          r_pwm;
    logic          w_boundary;
    logic          w_mismatch;

    pwm_period_counter #(.CLK_DIV(CLK_DIV)) u_counter (
        .i_clock    (i_clock),
        .i_reset    (i_reset),
        .i_enable   (i_pwm_enable),
        .o_cnt      (w_cnt),
        .o_boundary (w_boundary)
    );

    // A pending reversal first drives the ratio toward zero.
    assign w_mismatch = (r_dir != r_tdir);
    assign w_goal     = w_mismatch ? 8'd0 : r_target;
    assign w_slewed   = slew_toward(r_applied, w_goal, STEP);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_applied_nxt = r_applied;
        w_dir_nxt     = r_dir;
        w_brake_nxt   = r_brake_cnt;
        w_done_nxt    = 1'b0;
        if (!i_pwm_enable) begin
            w_state_nxt   = ST_HOLD;
            w_applied_nxt = 8'd0;
            w_dir_nxt     = r_tdir;
            w_brake_nxt   = '0;
            w_done_nxt    = r_pending && !r_done;
        end else if (w_boundary) begin
            case (r_state)
                ST_BRAKE: begin
                    if (r_brake_cnt == BRAKE_LAST) begin
                        w_dir_nxt   = r_tdir;
                        w_brake_nxt = '0;
                        w_state_nxt = (r_target == 8'd0) ? ST_HOLD : ST_RAMP;
                    end else begin
                        w_brake_nxt = r_brake_cnt + BW'(1);
                    end
                end
                default: begin
                    w_applied_nxt = w_slewed;
                    if (w_mismatch && (w_slewed == 8'd0)) begin
                        w_state_nxt = ST_BRAKE;
                        w_brake_nxt = '0;
                    end else if (!w_mismatch && (w_slewed == r_target)) begin
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_state_nxt = ST_RAMP;
                    end
                end
            endcase
            w_done_nxt = r_pending && (w_state_nxt == ST_HOLD);
        end
    end

    // A strobe coinciding with completion keeps pending set: the newer request still needs its own done.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_applied   <= 8'd0;
            r_dir       <= 1'b0;
            r_brake_cnt <= '0;
            r_target    <= 8'd0;
            r_tdir      <= 1'b0;
            r_pending   <= 1'b0;
            r_done      <= 1'b0;
            r_pwm       <= 1'b0;
        end else begin
            r_applied   <= w_applied_nxt;
            r_dir       <= w_dir_nxt;
            r_brake_cnt <= w_brake_nxt;
            r_done      <= w_done_nxt;
            r_pwm       <= i_pwm_enable && (w_cnt < r_applied);
            if (i_pwm_update) begin
                r_target  <= i_pwm_ratio;
                r_tdir    <= i_pwm_direction;
                r_pending <= 1'b1;
            end else if (w_done_nxt) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_pwm_done      = r_done;
    assign o_pwm_out       = r_pwm;
    assign o_dir_out       = r_dir;
    assign o_applied_ratio = r_applied;

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: directed and randomized requests checked against a
// period-level reference model, with done events matched through a scoreboard.
`timescale 1ns/1ps
module tb_pwm_generator;

    localparam int CLK_DIV       = 2;
    localparam int RAMP_STEP     = 8;
    localparam int BRAKE_PERIODS = 2;
    localparam int P             = 255 * CLK_DIV;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       en       = 1'b0;
    logic       dir_in   = 1'b0;
    logic       upd      = 1'b0;
    logic [7:0] ratio_in = 8'd0;
    logic       done;
    logic       pwm;
    logic       dir_o;
    logic [7:0] applied;

    pwm_generator #(
        .CLK_DIV       (CLK_DIV),
        .RAMP_STEP     (RAMP_STEP),
        .BRAKE_PERIODS (BRAKE_PERIODS)
    ) dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_pwm_enable    (en),
        .i_pwm_ratio     (ratio_in),
        .i_pwm_direction (dir_in),
        .i_pwm_update    (upd),
        .o_pwm_done      (done),
        .o_pwm_out       (pwm),
        .o_dir_out       (dir_o),
        .o_applied_ratio (applied)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] ratio;
        logic       dir;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    // reference model state (period-level view of the motor request)
    int m_ph      = 0;
    int m_applied = 0;
    int m_dir     = 0;
    int m_target  = 0;
    int m_tdir    = 0;
    int m_bcount  = 0;
    int m_seg     = 0;
    bit m_pending = 0;
    bit m_braking = 0;
    bit m_done    = 0;
    bit m_bnd     = 0;
    bit m_clr     = 0;

    int acc       = 0;
    int done_cnt  = 0;
    bit prev_done = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model advances once per rising edge using the inputs that were stable before it.
    initial begin
        forever begin
            int  d;
            bit  dn;
            @(posedge clk);
            m_bnd = 0;
            m_clr = 0;
            dn    = 0;
            if (rst) begin
                m_ph = 0; m_applied = 0; m_dir = 0; m_target = 0; m_tdir = 0;
                m_bcount = 0; m_pending = 0; m_braking = 0; m_done = 0;
                m_clr = 1;
                sb.delete();
            end else begin
                if (!en) begin
                    m_ph = 0; m_applied = 0; m_dir = m_tdir; m_braking = 0; m_bcount = 0;
                    m_clr = 1;
                    if (m_pending && !m_done) begin
                        dn = 1;
                        m_pending = 0;
                        sb.push_back({8'd0, 1'b0 ^ m_dir[0]});
                    end
                end else if (m_ph == P - 1) begin
                    m_ph  = 0;
                    m_bnd = 1;
                    m_seg = m_applied;
                    if (m_braking) begin
                        m_bcount++;
                        if (m_bcount == BRAKE_PERIODS) begin
                            m_dir     = m_tdir;
                            m_braking = 0;
                        end
                    end else if (m_dir != m_tdir) begin
                        m_applied = m_applied - ((m_applied < RAMP_STEP) ? m_applied : RAMP_STEP);
                        if (m_applied == 0) begin
                            m_braking = 1;
                            m_bcount  = 0;
                        end
                    end else begin
                        d = m_target - m_applied;
                        if (d > RAMP_STEP)  d = RAMP_STEP;
                        if (d < -RAMP_STEP) d = -RAMP_STEP;
                        m_applied = m_applied + d;
                    end
                    if (m_pending && !m_braking && m_applied == m_target && m_dir == m_tdir) begin
                        dn = 1;
                        m_pending = 0;
                        sb.push_back({m_applied[7:0], m_dir[0]});
                    end
                end else begin
                    m_ph++;
                end
                if (upd) begin
                    m_target  = int'(ratio_in);
                    m_tdir    = int'(dir_in);
                    m_pending = 1;
                end
                m_done = dn;
            end
        end
    end

    // Monitor: duty/applied/dir at every boundary, done pulses against the scoreboard.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (m_clr) acc = 0;
            else acc += int'(pwm);
            if (m_bnd) begin
                check("duty_high_cycles", acc, m_seg * CLK_DIV);
                check("applied_at_boundary", int'(applied), m_applied);
                check("dir_at_boundary", int'(dir_o), m_dir);
                acc = 0;
            end
            if (done) begin
                done_cnt++;
                check("done_not_back_to_back", int'(prev_done), 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got a done pulse, expected none (applied=%0d)", applied);
                end else begin
                    e = sb.pop_front();
                    check("done_applied", int'(applied), int'(e.ratio));
                    check("done_dir", int'(dir_o), int'(e.dir));
                end
            end
            prev_done = done;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int r, input int d);
        @(negedge clk);
        ratio_in = 8'(r);
        dir_in   = d[0];
        upd      = 1'b1;
        @(negedge clk);
        upd      = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pwm"}, int'(pwm), 0);
        check({tag, "_dir"}, int'(dir_o), 0);
        check({tag, "_applied"}, int'(applied), 0);
    endtask

    initial begin
        int base;
        int hi;
        bit found;

        wait_cycles(3);
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;

        // ratio 0 in HOLD: low for a whole period
        hi = 0;
        repeat (P) begin
            @(negedge clk);
            hi += int'(pwm);
        end
        check("ratio0_high_cycles", hi, 0);

        // ramp 0 -> 64, one step per period, single done
        base = done_cnt;
        send(64, 0);
        wait_cycles(9 * P);
        check("t1_applied", int'(applied), 64);
        check("t1_done_count", done_cnt - base, 1);

        send(40, 0);
        wait_cycles(4 * P);
        check("t1b_applied", int'(applied), 40);

        // reversal: ramp down, brake, flip DIR, ramp back up
        base = done_cnt;
        send(40, 1);
        wait_cycles(13 * P);
        check("t3_applied", int'(applied), 40);
        check("t3_dir", int'(dir_o), 1);
        check("t3_done_count", done_cnt - base, 1);

        // latest request wins, one done
        base = done_cnt;
        send(100, 1);
        wait_cycles(2 * P);
        send(20, 1);
        wait_cycles(7 * P);
        check("t4_applied", int'(applied), 20);
        check("t4_done_count", done_cnt - base, 1);

        send(128, 0);
        wait_cycles(22 * P);
        check("t2_applied128", int'(applied), 128);
        check("t2_dir", int'(dir_o), 0);

        send(255, 0);
        wait_cycles(17 * P);
        check("t2_applied255", int'(applied), 255);
        hi = 0;
        repeat (P) begin
            @(negedge clk);
            hi += int'(pwm);
        end
        check("ratio255_high_cycles", hi, P);

        // disabled: request completes immediately, then re-enable ramps without a new done
        @(negedge clk);
        en = 1'b0;
        base = done_cnt;
        send(200, 1);
        wait_cycles(4);
        check("t5_pwm_low", int'(pwm), 0);
        check("t5_dir", int'(dir_o), 1);
        check("t5_applied", int'(applied), 0);
        check("t5_done_count", done_cnt - base, 1);
        @(negedge clk);
        en = 1'b1;
        wait_cycles(26 * P);
        check("t5_applied_after", int'(applied), 200);
        check("t5_done_total", done_cnt - base, 1);

        // reset mid-ramp
        @(negedge clk);
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        send(100, 0);
        found = 0;
        for (int i = 0; i < 10 * P && !found; i++) begin
            @(negedge clk);
            if (m_applied == 48) found = 1;
        end
        check("t6_reached_48", int'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("t6_reset");
        rst  = 1'b0;
        base = done_cnt;
        wait_cycles(3 * P);
        check("t6_no_done", done_cnt - base, 0);
        check("t6_applied", int'(applied), 0);

        // randomized requests, occasional enable drop
        for (int i = 0; i < 4; i++) begin
            wait_cycles($urandom_range(1, P));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                en = 1'b0;
                wait_cycles($urandom_range(1, 6));
                en = 1'b1;
            end
            send($urandom_range(0, 40), $urandom_range(0, 1));
        end

        // update landing in the boundary cycle
        found = 0;
        for (int i = 0; i < P + 2 && !found; i++) begin
            @(negedge clk);
            if (m_ph == P - 1) found = 1;
        end
        check("boundary_align_found", int'(found), 1);
        ratio_in = 8'($urandom_range(0, 40));
        dir_in   = 1'($urandom_range(0, 1));
        upd      = 1'b1;
        @(negedge clk);
        upd = 1'b0;

        wait_cycles(16 * P);
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
